sr_frame_ctrl: RTL

- Controller that sequences a right-shift deserializer: assembles WIDTH serial bits into a parallel frame.
- Each bit enters at the MSB and shifts right, so the first bit received ends in the LSB.
- Delivers each frame through a valid/ready output register.
- Sits between a serial bit source (bit-strobed) and a parallel consumer; flags overrun when the consumer stalls.

---
 rtl/sr_frame_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/sr_frame_ctrl.sv
// rtl/sr_frame_ctrl.sv - right-shift serial-to-parallel frame controller; optional parity via SR_FRAME_PARITY_EN
module sr_frame_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             bit_en,
    input  logic             sin,
    input  logic             out_ready,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] data,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

`ifdef SR_FRAME_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             commit;
    logic [WIDTH-1:0] commit_data;
    logic [WIDTH-1:0] shifted;
`ifdef SR_FRAME_PARITY_EN
    logic             par_q, par_d;
    logic             commit_par;
`endif

    // New bits enter at the MSB so the first bit received lands in the LSB.
    assign shifted = {sin, sreg_q[WIDTH-1:1]};

    // Frame sequencing: start/abort, bit assembly and frame completion.
    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        cnt_d       = cnt_q;
        commit      = 1'b0;
        commit_data = sreg_q;
`ifdef SR_FRAME_PARITY_EN
        commit_par  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // bit_en alongside start is deliberately ignored.
                if (start) begin
                    state_d = SHIFT;
                    sreg_d  = '0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                    sreg_d  = '0;
                    cnt_d   = '0;
                end else if (bit_en) begin
                    if (cnt_q == LAST_CNT) begin
`ifdef SR_FRAME_PARITY_EN
                        state_d = PAR;
                        sreg_d  = shifted;
                        cnt_d   = '0;
`else
                        commit      = 1'b1;
                        commit_data = shifted;
                        state_d     = IDLE;
                        sreg_d      = '0;
                        cnt_d       = '0;
`endif
                    end else begin
                        sreg_d = shifted;
                        cnt_d  = cnt_q + 1'b1;
                    end
                end
            end
`ifdef SR_FRAME_PARITY_EN
            PAR: begin
                if (abort) begin
                    state_d = IDLE;
                    sreg_d  = '0;
                    cnt_d   = '0;
                end else if (bit_en) begin
                    // Even parity: error when total ones including the parity bit is odd.
                    commit      = 1'b1;
                    commit_data = sreg_q;
                    commit_par  = ^{sreg_q, sin};
                    state_d     = IDLE;
                    sreg_d      = '0;
                    cnt_d       = '0;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                sreg_d  = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Output register: handshake, commit and sticky overrun (set beats clear).
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
`ifdef SR_FRAME_PARITY_EN
        par_d   = par_q;
`endif
        if (ovr_clr) begin
            ovr_d = 1'b0;
        end
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        if (commit) begin
            if (valid_q && !out_ready) begin
                ovr_d = 1'b1;
            end else begin
                data_d  = commit_data;
                valid_d = 1'b1;
`ifdef SR_FRAME_PARITY_EN
                par_d   = commit_par;
`endif
            end
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef SR_FRAME_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
`ifdef SR_FRAME_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign data      = data_q;
    assign out_valid = valid_q;
    assign busy      = (state_q != IDLE);
    assign overrun   = ovr_q;
`ifdef SR_FRAME_PARITY_EN
    assign parity_err = par_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
